qpsk_phase_demod: RTL

//  Receive-side QPSK symbol detector. Paired with the 100-sample/symbol sine-table QPSK modulator.

---
 rtl/qpsk_phase_demod.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/qpsk_phase_demod.sv
// QPSK symbol detector: correlates 100-sample symbols against sin/cos tables and decides the dibit.
// Latency: sym_valid two edges after the edge taking the last sample; no backpressure, data_valid gaps hold state.
`timescale 1ns/1ps
module qpsk_phase_demod #(
  parameter int DW     = 11,
  parameter int ACC_W  = 28,
  parameter int THRESH = 12_500_000
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic signed [DW-1:0]    data_in,
  input  logic                    data_valid,
  input  logic                    Sync,
  output logic                    O,
  output logic                    E,
  output logic                    sym_valid,
  output logic                    sym_err,
  output logic signed [ACC_W-1:0] corr_i,
  output logic signed [ACC_W-1:0] corr_q
);

  localparam int PW = 2 * DW;
  localparam logic [6:0] LAST_IDX = 7'd99;
  localparam logic [ACC_W-1:0] THRESH_U = ACC_W'(THRESH);

  typedef enum logic {ST_IDLE, ST_ACC} state_t;

  // First quadrant of round(1000*sin(2*pi*n/100)); the rest follows by symmetry.
  function automatic logic [9:0] quarter_mag(input logic [6:0] m);
    case (m)
      7'd0:    return 10'd0;
      7'd1:    return 10'd63;
      7'd2:    return 10'd125;
      7'd3:    return 10'd187;
      7'd4:    return 10'd249;
      7'd5:    return 10'd309;
      7'd6:    return 10'd368;
      7'd7:    return 10'd426;
      7'd8:    return 10'd482;
      7'd9:    return 10'd536;
      7'd10:   return 10'd588;
      7'd11:   return 10'd637;
      7'd12:   return 10'd685;
      7'd13:   return 10'd729;
      7'd14:   return 10'd771;
      7'd15:   return 10'd809;
      7'd16:   return 10'd844;
      7'd17:   return 10'd876;
      7'd18:   return 10'd905;
      7'd19:   return 10'd930;
      7'd20:   return 10'd951;
      7'd21:   return 10'd969;
      7'd22:   return 10'd982;
      7'd23:   return 10'd992;
      7'd24:   return 10'd998;
      default: return 10'd1000;
    endcase
  endfunction

  function automatic logic signed [DW-1:0] sin_lut(input logic [6:0] n);
    logic [6:0]           m;
    logic                 neg;
    logic signed [DW-1:0] mag;
    m   = n;
    neg = 1'b0;
    if (n >= 7'd75) begin
      m   = 7'd100 - n;
      neg = 1'b1;
    end else if (n >= 7'd50) begin
      m   = n - 7'd50;
      neg = 1'b1;
    end else if (n >= 7'd25) begin
      m   = 7'd50 - n;
    end
    mag = DW'(quarter_mag(m));
    return neg ? -mag : mag;
  endfunction

  state_t                   state_q, state_d;
  logic                     in_vld_q, in_vld_d;
  logic                     in_sync_q, in_sync_d;
  logic signed [DW-1:0]     in_dat_q, in_dat_d;
  logic [6:0]               idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic                     snap_vld_q, snap_vld_d;
  logic signed [ACC_W-1:0]  snap_i_q, snap_i_d, snap_q_q, snap_q_d;
  logic                     o_q, o_d, e_q, e_d;
  logic                     sym_valid_q, sym_valid_d, sym_err_q, sym_err_d;
  logic signed [ACC_W-1:0]  corr_i_q, corr_i_d, corr_q_q, corr_q_d;

  logic                     restart;
  logic [6:0]               tap_idx, cos_idx;
  logic signed [DW-1:0]     sin_v, cos_v;
  logic signed [PW-1:0]     prod_i, prod_q;
  logic signed [ACC_W-1:0]  ext_i, ext_q, sum_i, sum_q;
  logic [ACC_W-1:0]         abs_i, abs_q, max_abs;
  logic                     i_dom;

  // Samples are registered once before the correlator.
  always_comb begin
    in_vld_d  = data_valid;
    in_sync_d = data_valid & Sync;
    in_dat_d  = data_in;
  end

  always_comb begin
    restart = (state_q == ST_IDLE) || in_sync_q;
    tap_idx = restart ? 7'd0 : idx_q;
    cos_idx = (tap_idx >= 7'd75) ? (tap_idx - 7'd75) : (tap_idx + 7'd25);
    sin_v   = sin_lut(tap_idx);
    cos_v   = sin_lut(cos_idx);
    prod_i  = PW'(in_dat_q) * PW'(sin_v);
    prod_q  = PW'(in_dat_q) * PW'(cos_v);
    ext_i   = ACC_W'(prod_i);
    ext_q   = ACC_W'(prod_q);
    sum_i   = acc_i_q + ext_i;
    sum_q   = acc_q_q + ext_q;
  end

  // A restart (first sample or Sync) reloads the accumulators and discards any partial symbol.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    snap_vld_d = 1'b0;
    snap_i_d   = snap_i_q;
    snap_q_d   = snap_q_q;
    if (in_vld_q) begin
      if (restart) begin
        state_d = ST_ACC;
        acc_i_d = ext_i;
        acc_q_d = ext_q;
        idx_d   = 7'd1;
      end else if (idx_q == LAST_IDX) begin
        snap_vld_d = 1'b1;
        snap_i_d   = sum_i;
        snap_q_d   = sum_q;
        acc_i_d    = '0;
        acc_q_d    = '0;
        idx_d      = 7'd0;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        idx_d   = idx_q + 7'd1;
      end
    end
  end

  always_comb begin
    abs_i       = snap_i_q[ACC_W-1] ? -snap_i_q : snap_i_q;
    abs_q       = snap_q_q[ACC_W-1] ? -snap_q_q : snap_q_q;
    i_dom       = (abs_i >= abs_q);
    max_abs     = i_dom ? abs_i : abs_q;
    o_d         = o_q;
    e_d         = e_q;
    sym_err_d   = sym_err_q;
    corr_i_d    = corr_i_q;
    corr_q_d    = corr_q_q;
    sym_valid_d = 1'b0;
    if (snap_vld_q) begin
      sym_valid_d = 1'b1;
      corr_i_d    = snap_i_q;
      corr_q_d    = snap_q_q;
      sym_err_d   = (max_abs < THRESH_U);
      // O carries the sign of the dominant arm, E selects cos over sin.
      o_d         = i_dom ? snap_i_q[ACC_W-1] : snap_q_q[ACC_W-1];
      e_d         = ~i_dom;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      in_vld_q    <= 1'b0;
      in_sync_q   <= 1'b0;
      in_dat_q    <= '0;
      idx_q       <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      snap_vld_q  <= 1'b0;
      snap_i_q    <= '0;
      snap_q_q    <= '0;
      o_q         <= 1'b0;
      e_q         <= 1'b0;
      sym_valid_q <= 1'b0;
      sym_err_q   <= 1'b0;
      corr_i_q    <= '0;
      corr_q_q    <= '0;
    end else begin
      in_vld_q    <= in_vld_d;
      in_sync_q   <= in_sync_d;
      in_dat_q    <= in_dat_d;
      idx_q       <= idx_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      snap_vld_q  <= snap_vld_d;
      snap_i_q    <= snap_i_d;
      snap_q_q    <= snap_q_d;
      o_q         <= o_d;
      e_q         <= e_d;
      sym_valid_q <= sym_valid_d;
      sym_err_q   <= sym_err_d;
      corr_i_q    <= corr_i_d;
      corr_q_q    <= corr_q_d;
    end
  end

  assign O         = o_q;
  assign E         = e_q;
  assign sym_valid = sym_valid_q;
  assign sym_err   = sym_err_q;
  assign corr_i    = corr_i_q;
  assign corr_q    = corr_q_q;

endmodule
